enigma_step_controller: RTL and testbench
=========================================

// Module: enigma_step_controller
// PURPOSE
//  Upstream stepping stage for the three rotor_0_25 instances (left/middle/right).
//  Turns a raw keyboard key level into one-cycle step pulses per rotor.
//  Applies odometer carry at notch positions, including the Enigma middle-rotor double-step.
//  Keeps shadow rotor positions and flags when they are stable for the downstream substitution stage.
// PARAMETERS
//  NOTCH_R      16  right-rotor position at which the middle rotor steps on the next key (0..25)
//  NOTCH_M      4   middle-rotor position at which middle and left rotors step (0..25)
//  MAX_POS      25  last valid rotor position; stepping MAX_POS wraps to 0
//  SYNC_STAGES  2   flops in the key_level synchronizer (>=2)
// PORTS
//  clk              in   1  system clock
//  reset            in   1  asynchronous, active-high reset
//  key_level        in   1  raw key-held level, asynchronous to clk
//  load_init_state  in   1  synchronous load of initial rotor positions, level-sensitive
//  init_pos_l       in   5  initial left position; >MAX_POS loads 0
//  init_pos_m       in   5  initial middle position; >MAX_POS loads 0
//  init_pos_r       in   5  initial right position; >MAX_POS loads 0
//  step_pulse       out  3  {left,middle,right} one-cycle increment strobes
//  pos_l            out  7  shadow left position, zero-extended, 0..MAX_POS
//  pos_m            out  7  shadow middle position, zero-extended
//  pos_r            out  7  shadow right position, zero-extended
//  encode_valid     out  1  one-cycle strobe: positions final for this key press
//  busy             out  1  high outside IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, pos_*=0, step_pulse=0, encode_valid=0, busy=0, synchronizer=0.
//  - key_level passes through SYNC_STAGES flops, then a registered rising-edge detect (key_rise).
//  - FSM states: IDLE, STEP, SETTLE, HOLD.
//    - IDLE: key_rise -> STEP. Otherwise stay.
//    - STEP (1 cycle): step_pulse asserted; pos_* updated in the same edge; -> SETTLE.
//    - SETTLE (1 cycle): encode_valid=1; -> HOLD.
//    - HOLD: stay while synchronized key is high; key low -> IDLE.
//  - Step vector, computed from pre-step positions:
//    - r: always stepped.
//    - m: stepped if pos_r==NOTCH_R or pos_m==NOTCH_M (double-step).
//    - l: stepped if pos_m==NOTCH_M.
//  - Increment: pos+1; MAX_POS wraps to 0. Width is 7 bits; the upper 2 bits are always 0.
//  - Latency: key_rise at cycle t gives step_pulse and new pos_* at t+1, and encode_valid at t+2.
//    The earliest next step comes only after key low has been seen in HOLD.
//  - load_init_state has priority over everything except reset:
//    - While high: state=IDLE, pos_* <= clamped init_pos_*, step_pulse=0, encode_valid=0.
//    - The edge detector is re-armed to the current key level, so a held key does not step on load release.
//  - Load asserted mid-STEP/SETTLE: pulses are suppressed that cycle and the load wins.
//  - Key bounce inside STEP/SETTLE/HOLD is ignored. Only one step is taken per press.
//  - Reset mid-operation: everything returns to reset values immediately.
// STRUCTURE
//  - Shared package enigma_pkg holds:
//    - ROTOR_W=7, POS_W=5, MAX_POS, and the default notch constants;
//    - the FSM state encoding typedef (2-bit);
//    - function wrap_inc(pos), returning 0 after MAX_POS;
//    - function clamp_init(pos), returning 0 if >MAX_POS.
//  - Sub-module key_sync_edge: SYNC_STAGES synchronizer plus registered rise detect; outputs key_sync and key_rise.
//  - The FSM, the step-vector logic and the three position registers stay in this module.
// TESTING
//  1. Reset, then key press with all positions 0 -> step_pulse=3'b001 once; pos_r=1; encode_valid one cycle later.
//  2. Load L=0,M=0,R=16; press -> step_pulse=3'b011; pos=(0,1,17).
//  3. Double-step, load L=0,M=3,R=16:
//     - press 1 -> step_pulse 3'b011, pos (0,4,17);
//     - press 2 -> step_pulse 3'b111, pos (1,5,18).
//  4. Wrap: load L=25,M=4,R=25; press -> step_pulse 3'b111; pos=(0,5,0).
//  5. Load clamp and hold:
//     - init_pos_r=30 -> pos_r=0;
//     - key held across load release -> no step_pulse until key released and re-pressed.
//  6. Bounce and mid-op events:
//     - key toggled 4x during HOLD -> exactly one step;
//     - load asserted in the STEP cycle -> pos = init values, encode_valid stays 0;
//     - reset asserted in SETTLE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared constants, FSM encoding and position helpers for the Enigma stepping stage.
package enigma_pkg;
   localparam int ROTOR_W     = 7;
   localparam int POS_W       = 5;
   localparam int MAX_POS     = 25;
   localparam int DEF_NOTCH_R = 16;
   localparam int DEF_NOTCH_M = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STEP   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_HOLD   = 2'd3
   } step_state_t;

   function automatic logic [POS_W-1:0] wrap_inc(input logic [POS_W-1:0] pos,
                                                  input logic [POS_W-1:0] max_pos);
      wrap_inc = (pos >= max_pos) ? '0 : pos + 1'b1;
   endfunction

   function automatic logic [POS_W-1:0] clamp_init(input logic [POS_W-1:0] pos,
                                                    input logic [POS_W-1:0] max_pos);
      clamp_init = (pos > max_pos) ? '0 : pos;
   endfunction
endpackage

// File: rtl/key_sync_edge.sv
// Key level synchronizer followed by a registered rising-edge detector.
module key_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_level,
   input  logic i_rearm,
   output logic o_key_sync,
   output logic o_key_rise
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_rise;

   // r_prev always tracks the synced level, so holding i_rearm leaves no pending edge
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_key_level};
         r_prev <= r_sync[SYNC_STAGES-1];
         r_rise <= i_rearm ? 1'b0 : (r_sync[SYNC_STAGES-1] & ~r_prev);
      end
   end

   assign o_key_sync = r_sync[SYNC_STAGES-1];
   assign o_key_rise = r_rise;
endmodule

// File: rtl/enigma_step_controller.sv
// Converts key presses into per-rotor step strobes with odometer carry and
// middle-rotor double-step, tracking shadow rotor positions.
module enigma_step_controller
   import enigma_pkg::*;
#(
   parameter int NOTCH_R     = DEF_NOTCH_R,
   parameter int NOTCH_M     = DEF_NOTCH_M,
   parameter int MAX_POS     = enigma_pkg::MAX_POS,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               key_level,
   input  logic               load_init_state,
   input  logic [POS_W-1:0]   init_pos_l,
   input  logic [POS_W-1:0]   init_pos_m,
   input  logic [POS_W-1:0]   init_pos_r,
   output logic [2:0]         step_pulse,
   output logic [ROTOR_W-1:0] pos_l,
   output logic [ROTOR_W-1:0] pos_m,
   output logic [ROTOR_W-1:0] pos_r,
   output logic               encode_valid,
   output logic               busy
);
   localparam logic [POS_W-1:0] LP_MAX = POS_W'(MAX_POS);
   localparam logic [POS_W-1:0] LP_NR  = POS_W'(NOTCH_R);
   localparam logic [POS_W-1:0] LP_NM  = POS_W'(NOTCH_M);

   step_state_t      r_state;
   step_state_t      w_next;
   logic [POS_W-1:0] r_pos_l;
   logic [POS_W-1:0] r_pos_m;
   logic [POS_W-1:0] r_pos_r;
   logic [2:0]       r_step_vec;
   logic [2:0]       w_step_vec;
   logic             w_do_step;
   logic             w_key_sync;
   logic             w_key_rise;

   key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_sync_edge (
      .i_clk       (clk),
      .i_rst       (reset),
      .i_key_level (key_level),
      .i_rearm     (load_init_state),
      .o_key_sync  (w_key_sync),
      .o_key_rise  (w_key_rise)
   );

   // Middle rotor also steps when it sits on its own notch: the double-step
   always_comb begin
      w_next       = r_state;
      w_do_step    = 1'b0;
      step_pulse   = 3'b000;
      encode_valid = 1'b0;
      w_step_vec   = {(r_pos_m == LP_NM),
                      (r_pos_r == LP_NR) || (r_pos_m == LP_NM),
                      1'b1};
      if (load_init_state) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_key_rise) begin
                  w_next    = ST_STEP;
                  w_do_step = 1'b1;
               end
            end
            ST_STEP: begin
               step_pulse = r_step_vec;
               w_next     = ST_SETTLE;
            end
            ST_SETTLE: begin
               encode_valid = 1'b1;
               w_next       = ST_HOLD;
            end
            ST_HOLD: begin
               if (!w_key_sync) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_pos_l    <= '0;
         r_pos_m    <= '0;
         r_pos_r    <= '0;
         r_step_vec <= 3'b000;
      end else begin
         r_state <= w_next;
         if (load_init_state) begin
            r_pos_l <= clamp_init(init_pos_l, LP_MAX);
            r_pos_m <= clamp_init(init_pos_m, LP_MAX);
            r_pos_r <= clamp_init(init_pos_r, LP_MAX);
         end else if (w_do_step) begin
            r_step_vec <= w_step_vec;
            if (w_step_vec[2]) r_pos_l <= wrap_inc(r_pos_l, LP_MAX);
            if (w_step_vec[1]) r_pos_m <= wrap_inc(r_pos_m, LP_MAX);
            r_pos_r <= wrap_inc(r_pos_r, LP_MAX);
         end
      end
   end

   assign busy  = (r_state != ST_IDLE);
   assign pos_l = {{(ROTOR_W-POS_W){1'b0}}, r_pos_l};
   assign pos_m = {{(ROTOR_W-POS_W){1'b0}}, r_pos_m};
   assign pos_r = {{(ROTOR_W-POS_W){1'b0}}, r_pos_r};
endmodule

// File: tb/tb_enigma_step_controller.sv
// Directed bench for enigma_step_controller: table of load/press vectors plus
// hand-written sequences for held key, bounce, mid-step load and mid-step reset.
module tb_enigma_step_controller;
   logic       clk = 1'b0;
   logic       reset;
   logic       key_level;
   logic       load_init_state;
   logic [4:0] init_pos_l;
   logic [4:0] init_pos_m;
   logic [4:0] init_pos_r;
   logic [2:0] step_pulse;
   logic [6:0] pos_l;
   logic [6:0] pos_m;
   logic [6:0] pos_r;
   logic       encode_valid;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       do_load;
      logic [4:0] il;
      logic [4:0] im;
      logic [4:0] ir;
      logic [2:0] exp_step;
      logic [6:0] el;
      logic [6:0] em;
      logic [6:0] er;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   enigma_step_controller dut (
      .clk             (clk),
      .reset           (reset),
      .key_level       (key_level),
      .load_init_state (load_init_state),
      .init_pos_l      (init_pos_l),
      .init_pos_m      (init_pos_m),
      .init_pos_r      (init_pos_r),
      .step_pulse      (step_pulse),
      .pos_l           (pos_l),
      .pos_m           (pos_m),
      .pos_r           (pos_r),
      .encode_valid    (encode_valid),
      .busy            (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [4:0] clamp(input logic [4:0] p);
      clamp = (p > 5'd25) ? 5'd0 : p;
   endfunction

   task automatic do_load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r,
                          input string tag);
      @(negedge clk);
      init_pos_l      = l;
      init_pos_m      = m;
      init_pos_r      = r;
      load_init_state = 1'b1;
      repeat (2) @(negedge clk);
      load_init_state = 1'b0;
      check({tag, " load pos_l"}, pos_l, {2'b00, clamp(l)});
      check({tag, " load pos_m"}, pos_m, {2'b00, clamp(m)});
      check({tag, " load pos_r"}, pos_r, {2'b00, clamp(r)});
   endtask

   task automatic press(input logic [2:0] es, input logic [6:0] el, input logic [6:0] em,
                        input logic [6:0] er, input string tag);
      int cyc;
      cyc = 0;
      @(negedge clk);
      key_level = 1'b1;
      do begin
         @(negedge clk);
         cyc++;
      end while (step_pulse == 3'b000 && cyc < 10);
      check({tag, " latency"}, cyc, 4);
      check({tag, " step_pulse"}, step_pulse, es);
      check({tag, " pos_l"}, pos_l, el);
      check({tag, " pos_m"}, pos_m, em);
      check({tag, " pos_r"}, pos_r, er);
      check({tag, " enc in STEP"}, encode_valid, 0);
      check({tag, " busy"}, busy, 1);
      @(negedge clk);
      check({tag, " enc in SETTLE"}, encode_valid, 1);
      check({tag, " pulse in SETTLE"}, step_pulse, 0);
      @(negedge clk);
      check({tag, " enc in HOLD"}, encode_valid, 0);
      key_level = 1'b0;
      repeat (6) @(negedge clk);
      check({tag, " idle busy"}, busy, 0);
   endtask

   initial begin
      int   cnt;
      int   cyc;
      logic pat[13];

      vecs[0] = '{1'b0, 5'd0,  5'd0,  5'd0,  3'b001, 7'd0,  7'd0, 7'd1};
      vecs[1] = '{1'b1, 5'd0,  5'd0,  5'd16, 3'b011, 7'd0,  7'd1, 7'd17};
      vecs[2] = '{1'b1, 5'd0,  5'd3,  5'd16, 3'b011, 7'd0,  7'd4, 7'd17};
      vecs[3] = '{1'b0, 5'd0,  5'd0,  5'd0,  3'b111, 7'd1,  7'd5, 7'd18};
      vecs[4] = '{1'b1, 5'd25, 5'd4,  5'd25, 3'b111, 7'd0,  7'd5, 7'd0};
      vecs[5] = '{1'b0, 5'd0,  5'd0,  5'd0,  3'b001, 7'd0,  7'd5, 7'd1};
      vecs[6] = '{1'b1, 5'd31, 5'd31, 5'd30, 3'b001, 7'd0,  7'd0, 7'd1};
      vecs[7] = '{1'b1, 5'd3,  5'd25, 5'd16, 3'b011, 7'd3,  7'd0, 7'd17};
      vecs[8] = '{1'b1, 5'd12, 5'd4,  5'd16, 3'b111, 7'd13, 7'd5, 7'd17};
      vecs[9] = '{1'b0, 5'd0,  5'd0,  5'd0,  3'b001, 7'd13, 7'd5, 7'd18};

      reset           = 1'b1;
      key_level       = 1'b0;
      load_init_state = 1'b0;
      init_pos_l      = '0;
      init_pos_m      = '0;
      init_pos_r      = '0;
      repeat (3) @(negedge clk);
      check("reset step_pulse", step_pulse, 0);
      check("reset pos_l", pos_l, 0);
      check("reset pos_m", pos_m, 0);
      check("reset pos_r", pos_r, 0);
      check("reset encode_valid", encode_valid, 0);
      check("reset busy", busy, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].do_load)
            do_load(vecs[i].il, vecs[i].im, vecs[i].ir, $sformatf("vec%0d", i));
         press(vecs[i].exp_step, vecs[i].el, vecs[i].em, vecs[i].er, $sformatf("vec%0d", i));
      end

      // key held across load release must not step
      @(negedge clk);
      init_pos_l      = 5'd2;
      init_pos_m      = 5'd2;
      init_pos_r      = 5'd30;
      load_init_state = 1'b1;
      key_level       = 1'b1;
      repeat (5) @(negedge clk);
      load_init_state = 1'b0;
      check("held clamp pos_r", pos_r, 0);
      check("held pos_l", pos_l, 2);
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (step_pulse != 3'b000) cnt++;
      end
      check("held no step count", cnt, 0);
      check("held busy", busy, 0);
      key_level = 1'b0;
      repeat (5) @(negedge clk);
      press(3'b001, 7'd2, 7'd2, 7'd1, "repress");

      // bounce: a sampled drop during the STEP window, then glitches in HOLD
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      cnt = 0;
      @(negedge clk);
      key_level = 1'b1;
      for (int i = 1; i < 13; i++) begin
         @(negedge clk);
         if (step_pulse != 3'b000) cnt++;
         key_level = pat[i];
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (step_pulse != 3'b000) cnt++;
         #1 key_level = 1'b0;
         #2 key_level = 1'b1;
      end
      repeat (4) begin
         @(negedge clk);
         if (step_pulse != 3'b000) cnt++;
      end
      check("bounce step count", cnt, 1);
      check("bounce pos_r", pos_r, 2);
      check("bounce still HOLD", busy, 1);
      key_level = 1'b0;
      repeat (6) @(negedge clk);
      check("bounce idle", busy, 0);

      // load asserted during the STEP cycle
      @(negedge clk);
      key_level = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (step_pulse == 3'b000 && cyc < 10);
      check("midload reached STEP", (cyc < 10), 1);
      init_pos_l      = 5'd7;
      init_pos_m      = 5'd8;
      init_pos_r      = 5'd9;
      load_init_state = 1'b1;
      #1;
      check("midload pulse suppressed", step_pulse, 0);
      @(negedge clk);
      check("midload pos_l", pos_l, 7);
      check("midload pos_m", pos_m, 8);
      check("midload pos_r", pos_r, 9);
      check("midload enc", encode_valid, 0);
      check("midload busy", busy, 0);
      @(negedge clk);
      check("midload enc later", encode_valid, 0);
      load_init_state = 1'b0;
      key_level       = 1'b0;
      repeat (6) @(negedge clk);

      // reset asserted during SETTLE
      key_level = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (encode_valid == 1'b0 && cyc < 10);
      check("midreset reached SETTLE", (cyc < 10), 1);
      check("midreset pre pos_r", pos_r, 10);
      reset = 1'b1;
      #1;
      check("midreset step_pulse", step_pulse, 0);
      check("midreset enc", encode_valid, 0);
      check("midreset busy", busy, 0);
      check("midreset pos_l", pos_l, 0);
      check("midreset pos_m", pos_m, 0);
      check("midreset pos_r", pos_r, 0);
      key_level = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("post reset busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
